// File: rtl/id_ex_operand_stage.sv
// ID/EX boundary register with per-operand forwarding and load-use stall detection.
// Operands are forwarded from EX, EX/MEM and MEM/WB; load results still in flight stall ID.
module id_ex_operand_stage #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned RAW    = 5,
    parameter int unsigned CTRL_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_id_valid,
    input  logic [RAW-1:0]    i_id_rs1,
    input  logic [RAW-1:0]    i_id_rs2,
    input  logic              i_id_use_rs1,
    input  logic              i_id_use_rs2,
    input  logic [RAW-1:0]    i_id_rd,
    input  logic              i_id_we_reg,
    input  logic              i_id_is_load,
    input  logic [XLEN-1:0]   i_id_imm,
    input  logic [XLEN-1:0]   i_id_pc,
    input  logic [CTRL_W-1:0] i_id_ctrl,
    input  logic [XLEN-1:0]   i_rf_rd1,
    input  logic [XLEN-1:0]   i_rf_rd2,
    input  logic [XLEN-1:0]   i_ex_alu_res,
    input  logic              i_exmem_we,
    input  logic              i_exmem_is_load,
    input  logic [RAW-1:0]    i_exmem_rd,
    input  logic [XLEN-1:0]   i_exmem_data,
    input  logic              i_memwb_we,
    input  logic [RAW-1:0]    i_memwb_rd,
    input  logic [XLEN-1:0]   i_memwb_data,
    input  logic              i_flush,
    output logic              o_stall_id,
    output logic              o_ex_valid,
    output logic [XLEN-1:0]   o_ex_rs1_val,
    output logic [XLEN-1:0]   o_ex_rs2_val,
    output logic [RAW-1:0]    o_ex_rd,
    output logic              o_ex_we_reg,
    output logic              o_ex_is_load,
    output logic [XLEN-1:0]   o_ex_imm,
    output logic [XLEN-1:0]   o_ex_pc,
    output logic [CTRL_W-1:0] o_ex_ctrl
);

    logic              r_ex_valid;
    logic [XLEN-1:0]   r_ex_rs1_val;
    logic [XLEN-1:0]   r_ex_rs2_val;
    logic [RAW-1:0]    r_ex_rd;
    logic              r_ex_we_reg;
    logic              r_ex_is_load;
    logic [XLEN-1:0]   r_ex_imm;
    logic [XLEN-1:0]   r_ex_pc;
    logic [CTRL_W-1:0] r_ex_ctrl;

    logic [XLEN-1:0]   w_op1;
    logic [XLEN-1:0]   w_op2;
    logic              w_hz1;
    logic              w_hz2;
    logic              w_stall;

    // MEM/WB must be forwarded too: the regfile has no write-through.
    always_comb begin
        w_op1 = i_rf_rd1;
        if (i_id_rs1 == '0)
            w_op1 = '0;
        else if (r_ex_valid && r_ex_we_reg && (r_ex_rd == i_id_rs1) && !r_ex_is_load)
            w_op1 = i_ex_alu_res;
        else if (i_exmem_we && (i_exmem_rd == i_id_rs1) && !i_exmem_is_load)
            w_op1 = i_exmem_data;
        else if (i_memwb_we && (i_memwb_rd == i_id_rs1))
            w_op1 = i_memwb_data;
    end

    always_comb begin
        w_op2 = i_rf_rd2;
        if (i_id_rs2 == '0)
            w_op2 = '0;
        else if (r_ex_valid && r_ex_we_reg && (r_ex_rd == i_id_rs2) && !r_ex_is_load)
            w_op2 = i_ex_alu_res;
        else if (i_exmem_we && (i_exmem_rd == i_id_rs2) && !i_exmem_is_load)
            w_op2 = i_exmem_data;
        else if (i_memwb_we && (i_memwb_rd == i_id_rs2))
            w_op2 = i_memwb_data;
    end

    // Stall depends only on registered state and ID/pipeline control, never on ex_alu_res.
    always_comb begin
        w_hz1 = i_id_valid && i_id_use_rs1 && (i_id_rs1 != '0) &&
                ((r_ex_valid && r_ex_is_load && (r_ex_rd == i_id_rs1)) ||
                 (i_exmem_we && i_exmem_is_load && (i_exmem_rd == i_id_rs1)));
        w_hz2 = i_id_valid && i_id_use_rs2 && (i_id_rs2 != '0) &&
                ((r_ex_valid && r_ex_is_load && (r_ex_rd == i_id_rs2)) ||
                 (i_exmem_we && i_exmem_is_load && (i_exmem_rd == i_id_rs2)));
        w_stall = !i_rst && !i_flush && (w_hz1 || w_hz2);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush || w_stall) begin
            r_ex_valid   <= 1'b0;
            r_ex_rs1_val <= '0;
            r_ex_rs2_val <= '0;
            r_ex_rd      <= '0;
            r_ex_we_reg  <= 1'b0;
            r_ex_is_load <= 1'b0;
            r_ex_imm     <= '0;
            r_ex_pc      <= '0;
            r_ex_ctrl    <= '0;
        end else begin
            r_ex_valid   <= i_id_valid;
            r_ex_rs1_val <= w_op1;
            r_ex_rs2_val <= w_op2;
            r_ex_rd      <= i_id_rd;
            r_ex_we_reg  <= i_id_valid && i_id_we_reg;
            r_ex_is_load <= i_id_valid && i_id_is_load;
            r_ex_imm     <= i_id_imm;
            r_ex_pc      <= i_id_pc;
            r_ex_ctrl    <= i_id_ctrl;
        end
    end

    assign o_stall_id   = w_stall;
    assign o_ex_valid   = r_ex_valid;
    assign o_ex_rs1_val = r_ex_rs1_val;
    assign o_ex_rs2_val = r_ex_rs2_val;
    assign o_ex_rd      = r_ex_rd;
    assign o_ex_we_reg  = r_ex_we_reg;
    assign o_ex_is_load = r_ex_is_load;
    assign o_ex_imm     = r_ex_imm;
    assign o_ex_pc      = r_ex_pc;
    assign o_ex_ctrl    = r_ex_ctrl;

endmodule
